// File: rtl/nru_set_if.sv
// Request/response bundle for one NRU-managed cache set: lookup/fill requests,
// partition-mask loads and the exported per-way state.
interface nru_set_if #(
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_WIDTH = 4
);
  logic                             os_req;
  logic [NUM_WAYS-1:0]              hitmap;
  logic                             user_req;
  logic [ADDR_WIDTH-1:0]            addr;
  logic                             hit;
  logic                             hit_valid;
  logic [NUM_WAYS-1:0]              metadata_o;
  logic [ADDR_WIDTH*NUM_WAYS-1:0]   all_tags_o;
  logic [NUM_WAYS-1:0]              all_valid_o;
  logic [NUM_WAYS-1:0]              policy_hitmap_o;

  modport master (
    output os_req, hitmap, user_req, addr,
    input  hit, hit_valid, metadata_o, all_tags_o, all_valid_o, policy_hitmap_o
  );
  modport slave (
    input  os_req, hitmap, user_req, addr,
    output hit, hit_valid, metadata_o, all_tags_o, all_valid_o, policy_hitmap_o
  );
endinterface

// File: rtl/nru_set.sv
// One cache set with Not-Recently-Used replacement and single-cycle lookup/fill.
// Define NRU_PARTITION_EN to add the os_req-loaded way partition mask.
module nru_set #(
  parameter int NUM_WAYS   = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  nru_set_if.slave   bus
);

  logic [ADDR_WIDTH-1:0] tag_reg [NUM_WAYS];
  logic [NUM_WAYS-1:0]   valid_reg;
  logic [NUM_WAYS-1:0]   nru_reg;
  logic [NUM_WAYS-1:0]   policy_reg;
  logic                  hit_reg;
  logic                  hit_valid_reg;

  logic [NUM_WAYS-1:0]   eligible;
  logic [NUM_WAYS-1:0]   match;
  logic [NUM_WAYS-1:0]   victim;
  logic [NUM_WAYS-1:0]   touched;
  logic [NUM_WAYS-1:0]   nru_upd;
  logic [NUM_WAYS-1:0]   nru_next;
  logic                  accept;
  logic                  hit_any;
  logic                  found;

`ifdef NRU_PARTITION_EN
  logic [NUM_WAYS-1:0] mask_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mask_reg <= '1;
    else if (bus.os_req)
      mask_reg <= bus.hitmap;
  end

  assign eligible = mask_reg;
  // A mask load pre-empts any user request in the same cycle.
  assign accept   = bus.user_req & ~bus.os_req;
`else
  logic unused_partition;
  assign unused_partition = ^{bus.os_req, bus.hitmap};
  assign eligible = '1;
  assign accept   = bus.user_req;
`endif

  assign hit_any = |match;

  // Victim priority: empty eligible way, then eligible NRU-clear way, then any
  // eligible way (only reachable when a shrunken mask leaves all bits set).
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && eligible[i] && !valid_reg[i]) begin
        victim[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && eligible[i] && !nru_reg[i]) begin
        victim[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!found && eligible[i]) begin
        victim[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    touched  = hit_any ? match : victim;
    nru_upd  = nru_reg | touched;
    nru_next = nru_upd;
    if ((eligible != '0) && ((nru_upd & eligible) == eligible))
      nru_next = (nru_upd & ~eligible) | touched;
  end

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign match[gi] = valid_reg[gi] && (tag_reg[gi] == bus.addr);
      assign bus.all_tags_o[ADDR_WIDTH*gi +: ADDR_WIDTH] = tag_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          tag_reg[gi]   <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (accept && !hit_any && victim[gi]) begin
          tag_reg[gi]   <= bus.addr;
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nru_reg       <= '0;
      policy_reg    <= '0;
      hit_reg       <= 1'b0;
      hit_valid_reg <= 1'b0;
    end else begin
      hit_valid_reg <= accept;
      if (accept) begin
        nru_reg    <= nru_next;
        policy_reg <= touched;
        hit_reg    <= hit_any;
      end
    end
  end

  assign bus.hit             = hit_reg;
  assign bus.hit_valid       = hit_valid_reg;
  assign bus.metadata_o      = nru_reg;
  assign bus.all_valid_o     = valid_reg;
  assign bus.policy_hitmap_o = policy_reg;

endmodule

// File: tb/tb_nru_set.sv
// Self-checking bench for nru_set: reference model feeds a scoreboard queue,
// scenario tasks add directed checks on top.
module tb_nru_set;
  localparam int NW = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nru_set_if #(.NUM_WAYS(NW), .ADDR_WIDTH(AW)) bus ();
  nru_set #(.NUM_WAYS(NW), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic          hit;
    logic          hv;
    logic [NW-1:0] pol;
    logic [NW-1:0] nru;
    logic [NW-1:0] valid;
    logic [NW*AW-1:0] tags;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] m_tag [NW];
  logic [NW-1:0] m_valid, m_nru, m_mask, m_pol;
  logic          m_hit, m_hv;

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) m_tag[i] = '0;
    m_valid = '0; m_nru = '0; m_mask = '1; m_pol = '0; m_hit = 0; m_hv = 0;
    sb.delete();
  endfunction

  function automatic void model_step(input logic os, input logic [NW-1:0] hm,
                                     input logic ur, input logic [AW-1:0] a);
    logic acc;
    int hw, vw;
    logic [NW-1:0] t;
    exp_t e;
    acc = ur;
`ifdef NRU_PARTITION_EN
    if (os) begin
      m_mask = hm;
      acc = 1'b0;
    end
`endif
    m_hv = acc;
    if (acc) begin
      t  = '0;
      hw = -1;
      for (int i = 0; i < NW; i++) if (m_valid[i] && m_tag[i] == a) hw = i;
      if (hw >= 0) begin
        m_hit = 1'b1;
        t[hw] = 1'b1;
      end else begin
        m_hit = 1'b0;
        vw = -1;
        for (int i = NW-1; i >= 0; i--) if (m_mask[i] && !m_valid[i]) vw = i;
        if (vw < 0) for (int i = NW-1; i >= 0; i--) if (m_mask[i] && !m_nru[i]) vw = i;
        if (vw < 0) for (int i = NW-1; i >= 0; i--) if (m_mask[i]) vw = i;
        if (vw >= 0) begin
          m_tag[vw]   = a;
          m_valid[vw] = 1'b1;
          t[vw]       = 1'b1;
        end
      end
      m_nru = m_nru | t;
      if (m_mask != '0 && (m_nru & m_mask) == m_mask) m_nru = (m_nru & ~m_mask) | t;
      m_pol = t;
    end
    e.hit = m_hit; e.hv = m_hv; e.pol = m_pol; e.nru = m_nru; e.valid = m_valid;
    for (int i = 0; i < NW; i++) e.tags[AW*i +: AW] = m_tag[i];
    sb.push_back(e);
  endfunction

  task automatic drive(input logic os, input logic [NW-1:0] hm,
                       input logic ur, input logic [AW-1:0] a);
    exp_t e;
    @(negedge clk);
    bus.os_req = os; bus.hitmap = hm; bus.user_req = ur; bus.addr = a;
    model_step(os, hm, ur, a);
    @(posedge clk);
    #1;
    bus.os_req = 1'b0; bus.user_req = 1'b0;
    e = sb.pop_front();
    $display("txn os=%0b hm=%b ur=%0b addr=%0d -> hit=%0b hv=%0b pol=%b nru=%b valid=%b",
             os, hm, ur, a, bus.hit, bus.hit_valid, bus.policy_hitmap_o, bus.metadata_o, bus.all_valid_o);
    n_checks++; if (bus.hit_valid !== e.hv) begin n_fail++; $display("FAIL sb_hit_valid got %b want %b", bus.hit_valid, e.hv); end
    n_checks++; if (bus.hit !== e.hit) begin n_fail++; $display("FAIL sb_hit got %b want %b", bus.hit, e.hit); end
    n_checks++; if (bus.policy_hitmap_o !== e.pol) begin n_fail++; $display("FAIL sb_policy got %b want %b", bus.policy_hitmap_o, e.pol); end
    n_checks++; if (bus.metadata_o !== e.nru) begin n_fail++; $display("FAIL sb_metadata got %b want %b", bus.metadata_o, e.nru); end
    n_checks++; if (bus.all_valid_o !== e.valid) begin n_fail++; $display("FAIL sb_valid got %b want %b", bus.all_valid_o, e.valid); end
    n_checks++; if (bus.all_tags_o !== e.tags) begin n_fail++; $display("FAIL sb_tags got %h want %h", bus.all_tags_o, e.tags); end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++; if (bus.hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", bus.hit); end
    n_checks++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hv got %b want 0", bus.hit_valid); end
    n_checks++; if (bus.metadata_o !== 4'b0000) begin n_fail++; $display("FAIL reset_meta got %b want 0000", bus.metadata_o); end
    n_checks++; if (bus.all_valid_o !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b want 0000", bus.all_valid_o); end
    n_checks++; if (bus.all_tags_o !== 16'h0000) begin n_fail++; $display("FAIL reset_tags got %h want 0000", bus.all_tags_o); end
    n_checks++; if (bus.policy_hitmap_o !== 4'b0000) begin n_fail++; $display("FAIL reset_pol got %b want 0000", bus.policy_hitmap_o); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fill_saturation();
    drive(0, '0, 1, 4'd3);
    n_checks++; if (bus.hit !== 1'b0 || bus.hit_valid !== 1'b1) begin n_fail++; $display("FAIL first_miss hit/hv got %b%b want 01", bus.hit, bus.hit_valid); end
    n_checks++; if (bus.all_valid_o !== 4'b0001) begin n_fail++; $display("FAIL first_miss valid got %b want 0001", bus.all_valid_o); end
    n_checks++; if (bus.all_tags_o[3:0] !== 4'd3) begin n_fail++; $display("FAIL first_miss tag0 got %0d want 3", bus.all_tags_o[3:0]); end
    n_checks++; if (bus.policy_hitmap_o !== 4'b0001) begin n_fail++; $display("FAIL first_miss pol got %b want 0001", bus.policy_hitmap_o); end
    drive(0, '0, 1, 4'd5);
    n_checks++; if (bus.metadata_o !== 4'b0011) begin n_fail++; $display("FAIL fill2 meta got %b want 0011", bus.metadata_o); end
    drive(0, '0, 1, 4'd7);
    n_checks++; if (bus.metadata_o !== 4'b0111) begin n_fail++; $display("FAIL fill3 meta got %b want 0111", bus.metadata_o); end
    drive(0, '0, 1, 4'd9);
    n_checks++; if (bus.metadata_o !== 4'b1000) begin n_fail++; $display("FAIL saturate meta got %b want 1000", bus.metadata_o); end
    n_checks++; if (bus.all_valid_o !== 4'b1111) begin n_fail++; $display("FAIL fill4 valid got %b want 1111", bus.all_valid_o); end
    drive(0, '0, 1, 4'd3);
    n_checks++; if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL rehit hit got %b want 1", bus.hit); end
    n_checks++; if (bus.policy_hitmap_o !== 4'b0001) begin n_fail++; $display("FAIL rehit pol got %b want 0001", bus.policy_hitmap_o); end
    n_checks++; if (bus.metadata_o !== 4'b1001) begin n_fail++; $display("FAIL rehit meta got %b want 1001", bus.metadata_o); end
    drive(0, '0, 0, 4'd0);
    n_checks++; if (bus.hit_valid !== 1'b0 || bus.hit !== 1'b1) begin n_fail++; $display("FAIL idle hv/hit got %b%b want 01", bus.hit_valid, bus.hit); end
  endtask

`ifdef NRU_PARTITION_EN
  task automatic test_partition();
    logic [NW-1:0] snap_nru, snap_valid;
    logic [NW*AW-1:0] snap_tags;
    pulse_reset();
    drive(1, 4'b0011, 0, 4'd0);
    drive(0, '0, 1, 4'd1);
    drive(0, '0, 1, 4'd2);
    drive(0, '0, 1, 4'd4);
    n_checks++; if (bus.all_valid_o !== 4'b0011) begin n_fail++; $display("FAIL part valid got %b want 0011", bus.all_valid_o); end
    n_checks++; if (bus.all_tags_o[7:0] !== 8'h24) begin n_fail++; $display("FAIL part tags got %h want 24", bus.all_tags_o[7:0]); end
    n_checks++; if (bus.metadata_o !== 4'b0001) begin n_fail++; $display("FAIL part meta got %b want 0001", bus.metadata_o); end
    drive(1, 4'b1100, 0, 4'd0);
    drive(0, '0, 1, 4'd2);
    n_checks++; if (bus.hit !== 1'b1 || bus.policy_hitmap_o !== 4'b0010) begin n_fail++; $display("FAIL outside_mask hit=%b pol=%b want 1 0010", bus.hit, bus.policy_hitmap_o); end
    snap_nru = bus.metadata_o; snap_valid = bus.all_valid_o; snap_tags = bus.all_tags_o;
    drive(1, 4'b0100, 1, 4'd6);
    n_checks++; if (bus.hit_valid !== 1'b0) begin n_fail++; $display("FAIL collide hv got %b want 0", bus.hit_valid); end
    n_checks++; if (bus.metadata_o !== snap_nru || bus.all_valid_o !== snap_valid || bus.all_tags_o !== snap_tags)
      begin n_fail++; $display("FAIL collide state got %b/%b/%h want %b/%b/%h", bus.metadata_o, bus.all_valid_o, bus.all_tags_o, snap_nru, snap_valid, snap_tags); end
    drive(0, '0, 1, 4'd6);
    n_checks++; if (bus.hit !== 1'b0 || bus.policy_hitmap_o !== 4'b0100) begin n_fail++; $display("FAIL collide_mask hit=%b pol=%b want 0 0100", bus.hit, bus.policy_hitmap_o); end
    drive(1, 4'b0000, 0, 4'd0);
    drive(0, '0, 1, 4'd13);
    n_checks++; if (bus.hit_valid !== 1'b1 || bus.hit !== 1'b0 || bus.policy_hitmap_o !== 4'b0000)
      begin n_fail++; $display("FAIL empty_mask hv=%b hit=%b pol=%b want 1 0 0000", bus.hit_valid, bus.hit, bus.policy_hitmap_o); end
  endtask
`else
  task automatic test_os_ignored();
    drive(1, 4'b0001, 1, 4'd11);
    n_checks++; if (bus.hit_valid !== 1'b1) begin n_fail++; $display("FAIL os_ignored hv got %b want 1", bus.hit_valid); end
  endtask
`endif

  task automatic test_async_reset();
    pulse_reset();
    drive(0, '0, 1, 4'd8);
    drive(0, '0, 1, 4'd7);
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({bus.hit, bus.hit_valid, bus.metadata_o, bus.all_valid_o, bus.policy_hitmap_o, bus.all_tags_o} !== '0)
      begin n_fail++; $display("FAIL async_reset outputs got hv=%b valid=%b meta=%b tags=%h want all 0", bus.hit_valid, bus.all_valid_o, bus.metadata_o, bus.all_tags_o); end
    #1 reset = 1'b0;
    model_reset();
    drive(0, '0, 1, 4'd5);
    n_checks++; if (bus.all_valid_o !== 4'b0001 || bus.all_tags_o[3:0] !== 4'd5 || bus.policy_hitmap_o !== 4'b0001)
      begin n_fail++; $display("FAIL post_reset_fill valid=%b tag0=%0d pol=%b want 0001 5 0001", bus.all_valid_o, bus.all_tags_o[3:0], bus.policy_hitmap_o); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] a;
      logic [NW-1:0] hm;
      logic os, ur;
      a  = AW'($urandom_range(0, 9));
      hm = NW'($urandom_range(1, 15));
      os = ($urandom_range(0, 7) == 0);
      ur = ($urandom_range(0, 5) != 0);
      drive(os, hm, ur, a);
    end
  endtask

  initial begin
    bus.os_req = 1'b0; bus.hitmap = '0; bus.user_req = 1'b0; bus.addr = '0;
    reset = 1'b0;
    model_reset();
    test_reset();
    test_fill_saturation();
`ifdef NRU_PARTITION_EN
    test_partition();
`else
    test_os_ignored();
`endif
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
